// File: rtl/risc521_seq_pkg.sv
// rtl/risc521_seq_pkg.sv - shared state encoding and MISR defaults for the vector sequencer
//
// Purpose : types and constants used by risc521_vector_seq and risc521_misr.
// Contents: seq_state_t (FSM encoding), DEF_POLY / DEF_SEED (MISR defaults),
//           width_of() helper for sizing counters.
package risc521_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CHECK = 2'd3
  } seq_state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/risc521_misr.sv
// rtl/risc521_misr.sv - multiple-input signature register used to compress the observed display
//
// Purpose : Galois-style MISR, sig <= (sig<<1) ^ (msb ? POLY : 0) ^ din.
// Ports   : Clk    in  clock
//           Resetn in  asynchronous active-low reset (sig -> SEED)
//           load   in  synchronous reload of SEED, wins over en
//           en     in  advance the signature by one step
//           din    in  SIG_W parallel input folded into the signature
//           sig    out SIG_W current signature
module risc521_misr
  import risc521_seq_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] feedback;

  assign feedback = sig[SIG_W-1] ? POLY : '0;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ feedback ^ din;
    end
  end

endmodule

// File: rtl/risc521_vector_seq.sv
// rtl/risc521_vector_seq.sv - applies a table of switch vectors to a DUT and signs its display output
//
// Purpose : on start, holds the DUT in reset for RST_CYCLES, then drives each of
//           NUM_VEC switch vectors for VEC_CYCLES cycles while folding disp_in
//           into a MISR and counting display changes, then compares the
//           signature with exp_sig.
// Ports   : Clk, Resetn        clock, asynchronous active-low reset
//           start, abort       run request (IDLE only), synchronous abort
//           sw_table           NUM_VEC packed vectors, vector i at [i*SW_W +: SW_W]
//           exp_sig            expected final signature
//           disp_in            DUT display under observation
//           dut_resetn, sw_out registered drive to the DUT
//           busy, done, pass   status: busy in HOLD/RUN/CHECK, done pulse, result
//           sig, chg_cnt       running signature, saturating display-change count
module risc521_vector_seq
  import risc521_seq_pkg::*;
#(
  parameter int               SW_W       = 5,
  parameter int               DISP_W     = 8,
  parameter int               NUM_VEC    = 4,
  parameter int               VEC_CYCLES = 20,
  parameter int               RST_CYCLES = 1,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED       = SIG_W'(DEF_SEED)
) (
  input  logic                      Clk,
  input  logic                      Resetn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_VEC*SW_W-1:0]   sw_table,
  input  logic [SIG_W-1:0]          exp_sig,
  input  logic [DISP_W-1:0]         disp_in,
  output logic                      dut_resetn,
  output logic [SW_W-1:0]           sw_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [SIG_W-1:0]          sig,
  output logic [7:0]                chg_cnt
);

  // One counter serves both HOLD and RUN, so size it for the longer of the two.
  localparam int CNT_MAX = (VEC_CYCLES > RST_CYCLES) ? VEC_CYCLES : RST_CYCLES;
  localparam int CNT_W   = width_of(CNT_MAX);
  localparam int IDX_W   = width_of(NUM_VEC);

  localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(VEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_VEC - 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [DISP_W-1:0] disp_prev;
  logic             abort_act;
  logic             misr_load;
  logic             misr_en;
  logic             rstn_nxt;
  logic [SW_W-1:0]  sw_nxt;
  logic             done_nxt;
  logic [SIG_W-1:0] din_ext;

  assign busy = (state != ST_IDLE);

  always_comb begin
    din_ext               = '0;
    din_ext[DISP_W-1:0]   = disp_in;
  end

  // Next-state, counters and decoded outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    misr_load = 1'b0;
    misr_en   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          misr_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        misr_en = 1'b1;
        if (cnt == VEC_LAST) begin
          cnt_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = ST_CHECK;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the state wanted to do.
    abort_act = abort && (state != ST_IDLE);
    if (abort_act) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end

    // DUT drive is decoded from where we are going so it lines up with the state.
    rstn_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_CHECK);
    sw_nxt   = (state_nxt == ST_RUN) ? sw_table[int'(idx_nxt)*SW_W +: SW_W] : '0;
    done_nxt = (state == ST_CHECK) && !abort_act;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt        <= '0;
      idx        <= '0;
      disp_prev  <= '0;
      chg_cnt    <= '0;
      pass       <= 1'b0;
      done       <= 1'b0;
      dut_resetn <= 1'b0;
      sw_out     <= '0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      done       <= done_nxt;
      dut_resetn <= rstn_nxt;
      sw_out     <= sw_nxt;

      if (misr_load) begin
        chg_cnt <= '0;
      end

      // HOLD primes disp_prev so the first RUN cycle does not count the
      // display's reset value as a change.
      if (state == ST_HOLD) begin
        disp_prev <= disp_in;
      end

      if (state == ST_RUN) begin
        if ((disp_in != disp_prev) && (chg_cnt != 8'hFF)) begin
          chg_cnt <= chg_cnt + 8'd1;
        end
        disp_prev <= disp_in;
      end

      if (misr_load || abort_act) begin
        pass <= 1'b0;
      end else if (state == ST_CHECK) begin
        pass <= (sig == exp_sig);
      end
    end
  end

  risc521_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .Clk    (Clk),
    .Resetn (Resetn),
    .load   (misr_load),
    .en     (misr_en),
    .din    (din_ext),
    .sig    (sig)
  );

endmodule

// File: tb/tb_risc521_vector_seq.sv
// tb/tb_risc521_vector_seq.sv - directed, table-driven bench for risc521_vector_seq
module tb_risc521_vector_seq;

  localparam int SW_W       = 5;
  localparam int DISP_W     = 8;
  localparam int NUM_VEC    = 2;
  localparam int VEC_CYCLES = 3;
  localparam int RST_CYCLES = 2;
  localparam int SIG_W      = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic                    start, abort;
  logic [NUM_VEC*SW_W-1:0] sw_table;
  logic [SIG_W-1:0]        exp_sig;
  logic [DISP_W-1:0]       disp_in;
  logic                    dut_resetn, busy, done, pass;
  logic [SW_W-1:0]         sw_out;
  logic [SIG_W-1:0]        sig;
  logic [7:0]              chg_cnt;

  logic                    start_s, abort_s;
  logic [SIG_W-1:0]        exp_sig_s;
  logic [DISP_W-1:0]       disp_s;
  logic                    dut_resetn_s, busy_s, done_s, pass_s;
  logic [SW_W-1:0]         sw_out_s;
  logic [SIG_W-1:0]        sig_s;
  logic [7:0]              chg_cnt_s;

  risc521_vector_seq #(
    .SW_W(SW_W), .DISP_W(DISP_W), .NUM_VEC(NUM_VEC), .VEC_CYCLES(VEC_CYCLES),
    .RST_CYCLES(RST_CYCLES), .SIG_W(SIG_W), .POLY(16'h1021), .SEED(16'h0000)
  ) dut (
    .Clk(clk), .Resetn(rst_n), .start(start), .abort(abort), .sw_table(sw_table),
    .exp_sig(exp_sig), .disp_in(disp_in), .dut_resetn(dut_resetn), .sw_out(sw_out),
    .busy(busy), .done(done), .pass(pass), .sig(sig), .chg_cnt(chg_cnt)
  );

  risc521_vector_seq #(
    .SW_W(SW_W), .DISP_W(DISP_W), .NUM_VEC(NUM_VEC), .VEC_CYCLES(200),
    .RST_CYCLES(RST_CYCLES), .SIG_W(SIG_W), .POLY(16'h1021), .SEED(16'h0000)
  ) dut_sat (
    .Clk(clk), .Resetn(rst_n), .start(start_s), .abort(abort_s), .sw_table(sw_table),
    .exp_sig(exp_sig_s), .disp_in(disp_s), .dut_resetn(dut_resetn_s), .sw_out(sw_out_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .sig(sig_s), .chg_cnt(chg_cnt_s)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic [7:0] disp;
    logic       busy;
    logic       rstn;
    logic [4:0] sw;
    logic       done;
  } vec_t;

  vec_t tbl[12];
  int   tbl_n;

  // One full run, start in row 0. Row 3 inputs land in the first RUN cycle.
  task automatic build_run(input logic [7:0] blip);
    tbl_n = 11;
    for (int i = 0; i < 11; i++) begin
      tbl[i].start = (i == 0);
      tbl[i].abort = 1'b0;
      tbl[i].disp  = (i == 3) ? blip : 8'h00;
      tbl[i].busy  = (i <= 8);
      tbl[i].rstn  = (i >= 2) && (i <= 8);
      tbl[i].sw    = (i >= 2 && i <= 4) ? 5'h15 : ((i >= 5 && i <= 7) ? 5'h0A : 5'h00);
      tbl[i].done  = (i == 9);
    end
  endtask

  // Start repeated while busy, abort during the second RUN cycle.
  task automatic build_abort();
    tbl_n = 9;
    for (int i = 0; i < 9; i++) begin
      tbl[i].start = (i <= 2);
      tbl[i].abort = (i == 4);
      tbl[i].disp  = 8'h00;
      tbl[i].busy  = (i <= 3);
      tbl[i].rstn  = (i == 2) || (i == 3);
      tbl[i].sw    = (i == 2 || i == 3) ? 5'h15 : 5'h00;
      tbl[i].done  = 1'b0;
    end
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < tbl_n; i++) begin
      start   = tbl[i].start;
      abort   = tbl[i].abort;
      disp_in = tbl[i].disp;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].busy);
      chk($sformatf("%s[%0d].dut_resetn", tag, i), dut_resetn, tbl[i].rstn);
      chk($sformatf("%s[%0d].sw_out", tag, i), sw_out, tbl[i].sw);
      chk($sformatf("%s[%0d].done", tag, i), done, tbl[i].done);
    end
    start = 1'b0;
    abort = 1'b0;
    disp_in = 8'h00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".dut_resetn"}, dut_resetn, 0);
    chk({tag, ".sw_out"}, sw_out, 0);
    chk({tag, ".sig"}, sig, 16'h0000);
    chk({tag, ".chg_cnt"}, chg_cnt, 0);
  endtask

  initial begin
    int  k;
    bit  seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; disp_in = '0;
    sw_table = {5'h0A, 5'h15}; exp_sig = 16'h0000;
    start_s = 1'b0; abort_s = 1'b0; exp_sig_s = 16'h0000; disp_s = '0;

    #2;
    chk_reset_outputs("reset0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run
    build_run(8'h00);
    apply_table("clean");
    chk("clean.pass", pass, 1);
    chk("clean.chg_cnt", chg_cnt, 0);
    chk("clean.sig", sig, 16'h0000);

    // Asynchronous reset while idle with pass set
    #2 rst_n = 1'b0;
    #1 chk("idle_reset.pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single blip, then a back-to-back rerun with a wrong expected signature
    exp_sig = 16'h0020;
    build_run(8'h01);
    apply_table("blip1");
    chk("blip1.sig", sig, 16'h0020);
    chk("blip1.chg_cnt", chg_cnt, 2);
    chk("blip1.pass", pass, 1);
    exp_sig = 16'h0021;
    apply_table("blip2");
    chk("blip2.sig", sig, 16'h0020);
    chk("blip2.chg_cnt", chg_cnt, 2);
    chk("blip2.pass", pass, 0);

    // Abort in the second RUN cycle
    exp_sig = 16'h0000;
    build_run(8'h00);
    apply_table("pre_abort");
    chk("pre_abort.pass", pass, 1);
    build_abort();
    apply_table("abort");
    chk("abort.pass", pass, 0);

    // Reset in the middle of RUN discards the run
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    disp_in = 8'h33;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("midrun.sig", sig, 16'h0055);
    chk("midrun.chg_cnt", chg_cnt, 1);
    chk("midrun.sw_out", sw_out, 5'h15);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    disp_in = 8'h00;
    repeat (4) @(negedge clk);
    chk("after_reset.busy", busy, 0);
    chk("after_reset.dut_resetn", dut_resetn, 0);
    chk("after_reset.done", done, 0);

    // Saturation on the long instance
    start_s = 1'b1;
    k = 0;
    seen = 1'b0;
    while (k < 600 && !seen) begin
      @(posedge clk); @(negedge clk);
      k++;
      start_s = 1'b0;
      disp_s  = ~disp_s;
      if (k == 3) begin
        chk("sat.busy", busy_s, 1);
        chk("sat.dut_resetn", dut_resetn_s, 1);
        chk("sat.sw_out", sw_out_s, 5'h15);
      end
      if (done_s) seen = 1'b1;
    end
    chk("sat.done_seen", seen, 1);
    chk("sat.run_length", k, 404);
    chk("sat.chg_cnt", chg_cnt_s, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/risc521_vector_seq.md
RISC521_VECTOR_SEQ -- requirements
Module: risc521_vector_seq

Interface
REQ-001 Parameter SW_W, default 5: width of the DUT switch input.
REQ-002 Parameter DISP_W, default 8: width of the DUT display output; SHALL be no wider than SIG_W.
REQ-003 Parameter NUM_VEC, default 4: number of switch vectors applied per run; SHALL be at least 1.
REQ-004 Parameter VEC_CYCLES, default 20: clock cycles each vector is held; SHALL be at least 1.
REQ-005 Parameter RST_CYCLES, default 1: clock cycles the DUT reset is held low after start; SHALL be at least 1.
REQ-006 Parameter SIG_W, default 16: width of the signature register (MISR).
REQ-007 Parameter POLY, default 16'h1021: MISR feedback polynomial.
REQ-008 Parameter SEED, default 0: MISR start value.
REQ-009 Clk  in  1  single clock; all state changes on the rising edge.
REQ-010 Resetn  in  1  asynchronous, active-low reset.
REQ-011 start  in  1  run request; sampled in IDLE only.
REQ-012 abort  in  1  synchronous abort request.
REQ-013 sw_table  in  NUM_VEC*SW_W  packed switch vectors; vector i is at [i*SW_W +: SW_W].
REQ-014 exp_sig  in  SIG_W  expected final signature.
REQ-015 disp_in  in  DISP_W  DUT display output under observation.
REQ-016 dut_resetn  out  1  active-low reset driven to the DUT.
REQ-017 sw_out  out  SW_W  switch value driven to the DUT.
REQ-018 busy  out  1  high in HOLD, RUN and CHECK.
REQ-019 done  out  1  one-cycle pulse at the end of a run.
REQ-020 pass  out  1  result flag; valid from done until the next start.
REQ-021 sig  out  SIG_W  current MISR value.
REQ-022 chg_cnt  out  8  number of disp_in changes seen during RUN; saturates.

Function
REQ-023 The FSM SHALL have four states: IDLE, HOLD, RUN and CHECK.
REQ-024 IDLE with start=1 SHALL go to HOLD and, on the same edge, load sig=SEED and clear chg_cnt, pass and the counters; start in any other state SHALL be ignored.
REQ-025 HOLD SHALL last exactly RST_CYCLES cycles, driving dut_resetn=0 and sw_out=0 and loading disp_prev<=disp_in every cycle; it SHALL then go to RUN with idx=0 and cnt=0.
REQ-026 RUN SHALL drive dut_resetn=1 and sw_out=vector[idx].
- cnt increments every cycle.
- At cnt==VEC_CYCLES-1, cnt wraps to 0 and idx increments.
- At cnt==VEC_CYCLES-1 with idx==NUM_VEC-1, the next state is CHECK.
- RUN therefore lasts exactly NUM_VEC*VEC_CYCLES cycles.
REQ-027 In every RUN cycle the MISR SHALL update as sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended disp_in.
REQ-028 In every RUN cycle the block SHALL increment chg_cnt when disp_in != disp_prev, saturating at 255, and SHALL then load disp_prev<=disp_in.
REQ-029 CHECK SHALL last one cycle with dut_resetn=1 and sw_out=0, register pass <= (sig==exp_sig), pulse done=1 in the following cycle, and return to IDLE.
REQ-030 IDLE SHALL drive dut_resetn=0 and sw_out=0, and SHALL hold sig, chg_cnt and pass unchanged.
REQ-031 abort=1 in HOLD, RUN or CHECK SHALL force IDLE on the next edge with pass=0 and no done pulse; abort has priority over every other transition and is ignored in IDLE.
REQ-032 sw_out and dut_resetn SHALL be registered outputs, decoded from the next state.

Reset
REQ-033 Resetn=0 SHALL asynchronously force the state to IDLE and set dut_resetn=0, sw_out=0, busy=0, done=0, pass=0, sig=SEED, chg_cnt=0, idx=0, cnt=0 and disp_prev=0.
REQ-034 Reset asserted mid-run SHALL discard the run; after release the block waits in IDLE for a new start.

Structure
REQ-035 The state encoding, the default POLY and the default SEED SHALL live in a shared package, risc521_seq_pkg.
REQ-036 The MISR SHALL be a separate sub-module, risc521_misr (parameters SIG_W, POLY, SEED; ports Clk, Resetn, load, en, din, sig).

Verification
All scenarios use NUM_VEC=2, VEC_CYCLES=3, RST_CYCLES=2, POLY=16'h1021, SEED=0 unless stated otherwise.
REQ-037 Reset: Resetn=0 at any time -> all outputs take their reset values immediately, without waiting for a clock edge.
REQ-038 Clean run: sw_table={5'h0A,5'h15}, disp_in=0, exp_sig=0, start pulse -> dut_resetn=0 for 2 cycles, then 1; sw_out=0x15 for 3 cycles, then 0x0A for 3 cycles; done for 1 cycle; pass=1, chg_cnt=0, sig=0x0000.
REQ-039 Single blip: disp_in=0x01 in the first RUN cycle only, exp_sig=0x0020 -> sig=0x0020, chg_cnt=2, pass=1; rerun with exp_sig=0x0021 -> pass=0.
REQ-040 Abort: abort=1 in the 2nd RUN cycle -> IDLE on the next edge; busy=0, dut_resetn=0, pass=0, no done pulse; start asserted while busy has no effect.
REQ-041 Saturation: VEC_CYCLES=200, disp_in toggles every cycle -> chg_cnt=255 at done.
REQ-042 Back-to-back runs: start asserted in the cycle after done -> second run is cycle-identical to the first and yields the same sig.
